// File: rtl/seq_stage_ctrl.sv
// Multi-cycle instruction sequencer: steps one instruction through FETCH..PCUPD with one-hot
// stage strobes. Optional perf counters are enabled by defining STAGE_CTRL_PERF_EN.
module seq_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        mem_ready_i,
  input  logic        dmem_error_i,
  output logic        fetch_en_o,
  output logic        decode_en_o,
  output logic        exec_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        pc_en_o,
  output logic [1:0]  stat_o,
  output logic        halted_o,
  output logic [31:0] retired_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcUpd, StHalt
  } state_e;

  localparam logic [1:0] StatAok = 2'b00;
  localparam logic [1:0] StatHlt = 2'b01;
  localparam logic [1:0] StatAdr = 2'b10;
  localparam logic [1:0] StatIns = 2'b11;
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  stat_q, stat_d;
  logic        is_mem_q, is_mem_d;
  logic [7:0]  wait_q, wait_d;
  logic [5:0]  strobe_q, strobe_d;
  logic        halted_q, halted_d;

  always_comb begin
    state_d  = state_q;
    stat_d   = stat_q;
    is_mem_d = is_mem_q;
    wait_d   = wait_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StFetch;
      end
      StFetch: begin
        if (imem_error_i) begin
          state_d = StHalt;
          stat_d  = StatAdr;
        end else if (!instr_valid_i) begin
          state_d = StHalt;
          stat_d  = StatIns;
        end else if (icode_i == 4'h0) begin
          state_d = StHalt;
          stat_d  = StatHlt;
        end else begin
          state_d  = StDecode;
          is_mem_d = icode_i inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: begin
        state_d = StMemory;
        wait_d  = '0;
      end
      StMemory: begin
        if (!is_mem_q) begin
          state_d = StWriteback;
        end else if (mem_ready_i) begin
          if (dmem_error_i) begin
            state_d = StHalt;
            stat_d  = StatAdr;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_q == WaitLast) begin
          // This is the MEM_TIMEOUT-th cycle without mem_ready.
          state_d = StHalt;
          stat_d  = StatAdr;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWriteback: state_d = StPcUpd;
      StPcUpd:     state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so each lines up with its stage cycle.
  always_comb begin
    strobe_d = '0;
    halted_d = 1'b0;
    unique case (state_d)
      StFetch:     strobe_d[5] = 1'b1;
      StDecode:    strobe_d[4] = 1'b1;
      StExecute:   strobe_d[3] = 1'b1;
      StMemory:    strobe_d[2] = 1'b1;
      StWriteback: strobe_d[1] = 1'b1;
      StPcUpd:     strobe_d[0] = 1'b1;
      StHalt:      halted_d    = 1'b1;
      default:     strobe_d    = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stat_q   <= StatAok;
      is_mem_q <= 1'b0;
      wait_q   <= '0;
      strobe_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      is_mem_q <= is_mem_d;
      wait_q   <= wait_d;
      strobe_q <= strobe_d;
      halted_q <= halted_d;
    end
  end

  assign fetch_en_o  = strobe_q[5];
  assign decode_en_o = strobe_q[4];
  assign exec_en_o   = strobe_q[3];
  assign mem_en_o    = strobe_q[2];
  assign wb_en_o     = strobe_q[1];
  assign pc_en_o     = strobe_q[0];
  assign stat_o      = stat_q;
  assign halted_o    = halted_q;

`ifdef STAGE_CTRL_PERF_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == StPcUpd && retired_q != '1) retired_q <= retired_q + 32'd1;
      if (state_q == StMemory && is_mem_q && !mem_ready_i && stall_q != '1) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_o      = retired_q;
  assign stall_cycles_o = stall_q;
`else
  assign retired_o      = '0;
  assign stall_cycles_o = '0;
`endif

endmodule
